// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer and run monitor for the RISC-V pipeline.
// Turns the board-level asynchronous active-low reset into synchronised,
// staggered per-channel active-high resets, then counts RUN cycles until
// the core halts (or the watchdog fires).
// Build option: define RSTSEQ_WDT_EN to build the RUN-cycle watchdog
// (timeout compare and TIMEOUT state). Without it, timeout stays 0 and
// RUN lasts until halt, with cycle_cnt saturating at all ones.
module rst_seq_ctrl #(
   parameter int unsigned N_CH        = 2,
   parameter int unsigned HOLD_CYC    = 4,
   parameter int unsigned STAGGER     = 2,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned TIMEOUT_CYC = 10000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sw_rst_req,
   input  logic             halt,
   output logic [N_CH-1:0]  rst_out,
   output logic             run,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_cnt
);

   // Counter widths: hold counts 0..HOLD_CYC-1, release counts 0..(N_CH-1)*STAGGER.
   localparam int unsigned HOLD_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int unsigned REL_MAX = (N_CH - 1) * STAGGER;
   localparam int unsigned REL_W   = (REL_MAX > 0) ? $clog2(REL_MAX + 1) : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(REL_MAX);
   localparam logic [N_CH-1:0]   RST_ALL   = '1;
   localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
   localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      ST_ASSERT  = 3'd0,
      ST_RELEASE = 3'd1,
      ST_RUN     = 3'd2,
      ST_HALTED  = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   // Registered state
   logic              r_sync_q1;
   logic              r_sync_q2;
   state_t            r_state;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [REL_W-1:0]  r_rel_cnt;
   logic [N_CH-1:0]   r_rst_out;
   logic              r_run;
   logic              r_done;
   logic              r_timeout;
   logic [CNT_W-1:0]  r_cycle_cnt;

   // Combinational next values
   state_t            w_state_nxt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic [REL_W-1:0]  w_rel_nxt;
   logic [N_CH-1:0]   w_rst_out_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_rst_sync;
   logic [HOLD_W-1:0] w_hold_inc;
   logic [REL_W-1:0]  w_rel_inc;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic [N_CH-1:0]   w_rel_hit;
   logic              w_to_hit;

   // Two-flop reset synchroniser: asserts with reset, releases on the 2nd edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync_q1 <= 1'b0;
         r_sync_q2 <= 1'b0;
      end else begin
         r_sync_q1 <= 1'b1;
         r_sync_q2 <= r_sync_q1;
      end
   end

   assign w_rst_sync = r_sync_q2;
   assign w_hold_inc = r_hold_cnt + HOLD_W'(1);
   assign w_rel_inc  = r_rel_cnt + REL_W'(1);
   assign w_cnt_inc  = (r_cycle_cnt == CNT_SAT) ? r_cycle_cnt : (r_cycle_cnt + CNT_W'(1));

   // Channel 0 is released on the edge leaving ASSERT; channel i>0 is released
   // on the edge where the release counter steps onto i*STAGGER.
   assign w_rel_hit[0] = 1'b0;
   genvar gi;
   generate
      for (gi = 1; gi < N_CH; gi++) begin : g_rel_hit
         localparam logic [REL_W-1:0] CH_AT = REL_W'(gi * STAGGER);
         assign w_rel_hit[gi] = (w_rel_inc == CH_AT);
      end
   endgenerate

`ifdef RSTSEQ_WDT_EN
   // Watchdog compare: the count about to reach TIMEOUT_CYC.
   assign w_to_hit = (r_cycle_cnt == TO_LAST);
`else
   // No watchdog: the compare is forced false, so it folds away and
   // TIMEOUT can never be entered.
   assign w_to_hit = 1'b0 & (r_cycle_cnt == TO_LAST);
`endif

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      w_state_nxt   = r_state;
      w_hold_nxt    = r_hold_cnt;
      w_rel_nxt     = r_rel_cnt;
      w_rst_out_nxt = r_rst_out;
      w_cnt_nxt     = r_cycle_cnt;

      case (r_state)
         ST_ASSERT: begin
            if (sw_rst_req) begin
               // A request while holding just restarts the hold period.
               w_hold_nxt = '0;
            end else if (w_rst_sync) begin
               if (r_hold_cnt == HOLD_LAST) begin
                  w_hold_nxt       = '0;
                  w_rel_nxt        = '0;
                  w_rst_out_nxt[0] = 1'b0;
                  // A single channel has nothing left to stagger.
                  w_state_nxt      = (N_CH == 1) ? ST_RUN : ST_RELEASE;
               end else begin
                  w_hold_nxt = w_hold_inc;
               end
            end
         end

         ST_RELEASE: begin
            if (sw_rst_req) begin
               w_state_nxt   = ST_ASSERT;
               w_hold_nxt    = '0;
               w_rel_nxt     = '0;
               w_rst_out_nxt = RST_ALL;
               w_cnt_nxt     = '0;
            end else begin
               w_rel_nxt     = w_rel_inc;
               w_rst_out_nxt = r_rst_out & ~w_rel_hit;
               if (w_rel_inc == REL_LAST) begin
                  w_state_nxt = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            if (sw_rst_req) begin
               w_state_nxt   = ST_ASSERT;
               w_hold_nxt    = '0;
               w_rel_nxt     = '0;
               w_rst_out_nxt = RST_ALL;
               w_cnt_nxt     = '0;
            end else if (halt) begin
               // Halt wins over the watchdog; the halt cycle is not counted.
               w_state_nxt = ST_HALTED;
            end else if (w_to_hit) begin
               w_state_nxt = ST_TIMEOUT;
               w_cnt_nxt   = w_cnt_inc;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end

         ST_HALTED, ST_TIMEOUT: begin
            // Terminal states: only a software request (or reset) leaves.
            if (sw_rst_req) begin
               w_state_nxt   = ST_ASSERT;
               w_hold_nxt    = '0;
               w_rel_nxt     = '0;
               w_rst_out_nxt = RST_ALL;
               w_cnt_nxt     = '0;
            end
         end

         default: begin
            // Unused encodings recover into a fresh sequence.
            w_state_nxt   = ST_ASSERT;
            w_hold_nxt    = '0;
            w_rel_nxt     = '0;
            w_rst_out_nxt = RST_ALL;
            w_cnt_nxt     = '0;
         end
      endcase
   end

   // State and sequencing counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_ASSERT;
         r_hold_cnt <= '0;
         r_rel_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_rel_cnt  <= w_rel_nxt;
      end
   end

   // Output registers, so nothing reaches a port combinationally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rst_out   <= RST_ALL;
         r_run       <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_cycle_cnt <= '0;
      end else begin
         r_rst_out   <= w_rst_out_nxt;
         r_run       <= (w_state_nxt == ST_RUN);
         r_done      <= (w_state_nxt == ST_HALTED);
         r_timeout   <= (w_state_nxt == ST_TIMEOUT);
         r_cycle_cnt <= w_cnt_nxt;
      end
   end

   assign rst_out   = r_rst_out;
   assign run       = r_run;
   assign done      = r_done;
   assign timeout   = r_timeout;
   assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: two instances (defaults, and N_CH=4/STAGGER=3/
// CNT_W=5/TIMEOUT_CYC=16) against a sequence-time model, plus directed
// literal checks at hand-counted edges.
module tb_rst_seq_ctrl;

`ifdef RSTSEQ_WDT_EN
   localparam bit WDT = 1'b1;
`else
   localparam bit WDT = 1'b0;
`endif

   // Model parameters per instance
   localparam int P_N  [2] = '{2, 4};
   localparam int P_H  [2] = '{4, 4};
   localparam int P_S  [2] = '{2, 3};
   localparam int P_W  [2] = '{32, 5};
   localparam int P_TO [2] = '{10000, 16};

   localparam int M_SEQ  = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;
   localparam int M_TO   = 3;

   logic        clk;
   logic        reset;
   logic        sw0, sw1, halt0, halt1;
   logic [1:0]  rst0;
   logic [3:0]  rst1;
   logic        run0, run1, done0, done1, to0, to1;
   logic [31:0] cnt0;
   logic [4:0]  cnt1;

   int n_chk  = 0;
   int n_pass = 0;

   rst_seq_ctrl u_dut0 (
      .clk        (clk),
      .reset      (reset),
      .sw_rst_req (sw0),
      .halt       (halt0),
      .rst_out    (rst0),
      .run        (run0),
      .done       (done0),
      .timeout    (to0),
      .cycle_cnt  (cnt0)
   );

   rst_seq_ctrl #(
      .N_CH        (4),
      .HOLD_CYC    (4),
      .STAGGER     (3),
      .CNT_W       (5),
      .TIMEOUT_CYC (16)
   ) u_dut1 (
      .clk        (clk),
      .reset      (reset),
      .sw_rst_req (sw1),
      .halt       (halt1),
      .rst_out    (rst1),
      .run        (run1),
      .done       (done1),
      .timeout    (to1),
      .cycle_cnt  (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: edges since reset release, sequence time t (edges counted with
   // the synchroniser released), mode and RUN count.
   int     m_sync [2];
   int     m_t    [2];
   int     m_mode [2];
   longint m_cnt  [2];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            m_sync[i] <= 0;
            m_t[i]    <= 0;
            m_mode[i] <= M_SEQ;
            m_cnt[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            logic   sw_v, halt_v;
            longint cmax;
            sw_v   = (i == 0) ? sw0 : sw1;
            halt_v = (i == 0) ? halt0 : halt1;
            cmax   = (longint'(1) << P_W[i]) - 1;
            m_sync[i] <= (m_sync[i] < 2) ? m_sync[i] + 1 : 2;
            if (sw_v) begin
               m_mode[i] <= M_SEQ;
               m_t[i]    <= 0;
               m_cnt[i]  <= 0;
            end else if (m_mode[i] == M_SEQ) begin
               if (m_sync[i] >= 2) begin
                  m_t[i] <= m_t[i] + 1;
                  if (m_t[i] + 1 == P_H[i] + (P_N[i] - 1) * P_S[i])
                     m_mode[i] <= M_RUN;
               end
            end else if (m_mode[i] == M_RUN) begin
               if (halt_v)
                  m_mode[i] <= M_HALT;
               else if (WDT && m_cnt[i] == P_TO[i] - 1) begin
                  m_mode[i] <= M_TO;
                  m_cnt[i]  <= m_cnt[i] + 1;
               end else if (m_cnt[i] < cmax)
                  m_cnt[i] <= m_cnt[i] + 1;
            end
         end
      end
   end

   // Channel ch is held until sequence time reaches HOLD + ch*STAGGER.
   function automatic logic [63:0] exp_rst(input int i);
      logic [63:0] r;
      r = '0;
      if (m_mode[i] == M_SEQ)
         for (int ch = 0; ch < P_N[i]; ch++)
            r[ch] = (m_t[i] < P_H[i] + ch * P_S[i]);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Per-cycle compare of both instances against the model.
   always @(negedge clk) begin
      chk("d0_rst_out", 64'(rst0), exp_rst(0));
      chk("d0_run", 64'(run0), 64'(m_mode[0] == M_RUN));
      chk("d0_done", 64'(done0), 64'(m_mode[0] == M_HALT));
      chk("d0_timeout", 64'(to0), 64'(m_mode[0] == M_TO));
      chk("d0_cycle_cnt", 64'(cnt0), 64'(m_cnt[0]));
      chk("d1_rst_out", 64'(rst1), exp_rst(1));
      chk("d1_run", 64'(run1), 64'(m_mode[1] == M_RUN));
      chk("d1_done", 64'(done1), 64'(m_mode[1] == M_HALT));
      chk("d1_timeout", 64'(to1), 64'(m_mode[1] == M_TO));
      chk("d1_cycle_cnt", 64'(cnt1), 64'(m_cnt[1]));
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish, got no $finish, expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; sw0 = 1'b0; sw1 = 1'b0; halt0 = 1'b0; halt1 = 1'b0;
      #20;
      chk("lit_reset_rst0", 64'(rst0), 64'h3);
      chk("lit_reset_rst1", 64'(rst1), 64'hF);
      chk("lit_reset_cnt0", 64'(cnt0), 64'h0);
      chk("lit_reset_run0", 64'(run0), 64'h0);
      #30 reset = 1'b1;                         // t=50, on a falling edge

      // Power-on sequence, edges counted from reset release
      step(5);                                  // e5
      chk("lit_e5_rst0", 64'(rst0), 64'h3);
      chk("lit_e5_model0", exp_rst(0), 64'h3);
      step(1);                                  // e6
      chk("lit_e6_rst0", 64'(rst0), 64'h2);
      chk("lit_e6_model0", exp_rst(0), 64'h2);
      chk("lit_e6_rst1", 64'(rst1), 64'hE);
      step(2);                                  // e8
      chk("lit_e8_rst0", 64'(rst0), 64'h0);
      chk("lit_e8_run0", 64'(run0), 64'h1);
      chk("lit_e8_rst1", 64'(rst1), 64'hE);
      step(1);                                  // e9
      chk("lit_e9_cnt0", 64'(cnt0), 64'h1);
      chk("lit_e9_rst1", 64'(rst1), 64'hC);
      step(6);                                  // e15
      chk("lit_e15_rst1", 64'(rst1), 64'h0);
      chk("lit_e15_run1", 64'(run1), 64'h1);

      // Halt DUT0 when its count reaches 20
      step(13);                                 // e28
      chk("lit_e28_cnt0", 64'(cnt0), 64'd20);
      halt0 = 1'b1;
      step(1);                                  // e29
      halt0 = 1'b0;
      chk("lit_halt_done0", 64'(done0), 64'h1);
      chk("lit_halt_run0", 64'(run0), 64'h0);
      chk("lit_halt_cnt0", 64'(cnt0), 64'd20);
      step(100);                                // e129
      chk("lit_frozen_cnt0", 64'(cnt0), 64'd20);
      chk("lit_frozen_rst0", 64'(rst0), 64'h0);
      // DUT1 never halted: watchdog stops it at 16, otherwise it saturates at 31
      chk("lit_wdt_to1", 64'(to1), WDT ? 64'h1 : 64'h0);
      chk("lit_wdt_cnt1", 64'(cnt1), WDT ? 64'd16 : 64'd31);
      chk("lit_wdt_run1", 64'(run1), WDT ? 64'h0 : 64'h1);

      // Software restart from HALTED (DUT0) and TIMEOUT/RUN (DUT1)
      sw0 = 1'b1; sw1 = 1'b1;
      step(1);                                  // E
      sw0 = 1'b0; sw1 = 1'b0;
      chk("lit_sw_rst0", 64'(rst0), 64'h3);
      chk("lit_sw_cnt0", 64'(cnt0), 64'h0);
      chk("lit_sw_done0", 64'(done0), 64'h0);
      chk("lit_sw_to1", 64'(to1), 64'h0);
      step(3);                                  // E+3
      chk("lit_sw_e3_rst0", 64'(rst0), 64'h3);
      step(1);                                  // E+4
      chk("lit_sw_e4_rst0", 64'(rst0), 64'h2);
      chk("lit_sw_e4_rst1", 64'(rst1), 64'hE);

      // Async reset in the middle of RELEASE
      #3 reset = 1'b0;
      #1;
      chk("lit_async_rst0", 64'(rst0), 64'h3);
      chk("lit_async_rst1", 64'(rst1), 64'hF);
      #20;
      @(negedge clk);
      reset = 1'b1;
      step(3);                                  // e3
      sw1 = 1'b1;                               // restart DUT1 hold while in ASSERT
      step(1);                                  // e4
      sw1 = 1'b0;
      step(1);                                  // e5
      chk("lit_r2_e5_rst0", 64'(rst0), 64'h3);
      step(1);                                  // e6
      chk("lit_r2_e6_rst0", 64'(rst0), 64'h2);
      chk("lit_r2_e6_rst1", 64'(rst1), 64'hF);
      step(2);                                  // e8
      chk("lit_r2_e8_rst0", 64'(rst0), 64'h0);
      chk("lit_r2_e8_run0", 64'(run0), 64'h1);
      chk("lit_r2_e8_rst1", 64'(rst1), 64'hE);
      halt1 = 1'b1;                             // ignored while DUT1 releases
      step(1);                                  // e9
      halt1 = 1'b0;
      step(2);                                  // e11
      chk("lit_r2_e11_rst1", 64'(rst1), 64'hC);
      chk("lit_r2_e11_done1", 64'(done1), 64'h0);

      // halt and sw_rst_req together in RUN: restart wins
      halt0 = 1'b1; sw0 = 1'b1;
      step(1);                                  // e12
      halt0 = 1'b0; sw0 = 1'b0;
      chk("lit_both_done0", 64'(done0), 64'h0);
      chk("lit_both_rst0", 64'(rst0), 64'h3);
      chk("lit_both_run0", 64'(run0), 64'h0);
      step(4);                                  // e16
      chk("lit_both_e16_rst0", 64'(rst0), 64'h2);
      sw0 = 1'b1;                               // restart during RELEASE
      step(1);                                  // e17
      sw0 = 1'b0;
      chk("lit_relsw_rst0", 64'(rst0), 64'h3);
      chk("lit_e17_rst1", 64'(rst1), 64'h0);
      chk("lit_e17_run1", 64'(run1), 64'h1);

      // DUT1: halt on the same edge the watchdog would fire
      step(15);                                 // e32
      chk("lit_e32_cnt1", 64'(cnt1), 64'd15);
      halt1 = 1'b1;
      step(1);                                  // e33
      halt1 = 1'b0;
      chk("lit_tie_done1", 64'(done1), 64'h1);
      chk("lit_tie_to1", 64'(to1), 64'h0);
      chk("lit_tie_cnt1", 64'(cnt1), 64'd15);

      step(10);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
